ram_bus_master: RTL

Initiator for the banked single-port synchronous RAM bus (addr / inout data / cs / we / oe). It accepts word read and write requests over a valid/ready handshake and sequences the RAM control strobes cycle by cycle. It owns the shared tristate data bus during writes and captures RAM-driven data during reads. Read results return on a valid/ready response channel. It sits between the CPU datapath and the large RAM array; its mem_* ports connect one-to-one to the array's ports.

---
 rtl/ram_bus_pkg.sv | 33 +++
 rtl/ram_bus_master_if.sv | 32 +++
 rtl/ram_bus_master.sv | 106 ++++++++++
 3 files changed

// File: rtl/ram_bus_pkg.sv
// rtl/ram_bus_pkg.sv - shared types and strobe decode for the RAM bus initiator
package ram_bus_pkg;

  localparam int TXN_COUNT_WIDTH = 16;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD_ADDR,
    RD_DATA,
    RSP
  } ram_bus_state_e;

  typedef struct packed {
    logic cs;
    logic we;
    logic oe;
    logic drive;
  } mem_ctl_t;

  // Strobe pattern the RAM must see while the FSM sits in state s.
  function automatic mem_ctl_t ctl_for(ram_bus_state_e s);
    mem_ctl_t c;
    c = '0;
    case (s)
      WR:               c = '{cs: 1'b1, we: 1'b1, oe: 1'b0, drive: 1'b1};
      RD_ADDR, RD_DATA: c = '{cs: 1'b1, we: 1'b0, oe: 1'b1, drive: 1'b0};
      default:          c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/ram_bus_master_if.sv
// rtl/ram_bus_master_if.sv - request/response handshake and RAM strobe bundle
interface ram_bus_master_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
);

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;

  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_cs;
  logic                  mem_we;
  logic                  mem_oe;

  modport master (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, mem_addr, mem_cs, mem_we, mem_oe
  );

  modport slave (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, mem_addr, mem_cs, mem_we, mem_oe
  );

endinterface

// File: rtl/ram_bus_master.sv
// rtl/ram_bus_master.sv - sequences cs/we/oe strobes for single-word RAM reads and writes
// The shared data bus stays a plain inout port so the RAM and this block resolve it directly.
module ram_bus_master
  import ram_bus_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  ram_bus_master_if.master           bus,
  inout  wire  [DATA_WIDTH-1:0]      mem_data,
  output logic                       busy,
  output logic [TXN_COUNT_WIDTH-1:0] txn_count
);

  ram_bus_state_e              state_q;
  mem_ctl_t                    ctl_q;
  logic [ADDR_WIDTH-1:0]       addr_q;
  logic [DATA_WIDTH-1:0]       wdata_q;
  logic [DATA_WIDTH-1:0]       rdata_q;
  logic                        req_ready_q;
  logic                        rsp_valid_q;
  logic                        busy_q;
  logic [TXN_COUNT_WIDTH-1:0]  txn_q;

  // Strobes are registered with the state so mem_* never see req_* combinationally.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      ctl_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      txn_q       <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            addr_q      <= bus.req_addr;
            wdata_q     <= bus.req_wdata;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            if (bus.req_we) begin
              state_q <= WR;
              ctl_q   <= ctl_for(WR);
            end else begin
              state_q <= RD_ADDR;
              ctl_q   <= ctl_for(RD_ADDR);
            end
          end
        end
        WR: begin
          txn_q       <= txn_q + TXN_COUNT_WIDTH'(1);
          state_q     <= IDLE;
          ctl_q       <= ctl_for(IDLE);
          req_ready_q <= 1'b1;
          busy_q      <= 1'b0;
        end
        RD_ADDR: begin
          state_q <= RD_DATA;
          ctl_q   <= ctl_for(RD_DATA);
        end
        RD_DATA: begin
          rdata_q     <= mem_data;
          rsp_valid_q <= 1'b1;
          state_q     <= RSP;
          ctl_q       <= ctl_for(RSP);
        end
        RSP: begin
          if (bus.rsp_ready) begin
            txn_q       <= txn_q + TXN_COUNT_WIDTH'(1);
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
            ctl_q       <= ctl_for(IDLE);
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          ctl_q       <= '0;
          rsp_valid_q <= 1'b0;
          req_ready_q <= 1'b1;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign mem_data = ctl_q.drive ? wdata_q : {DATA_WIDTH{1'bz}};

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_cs    = ctl_q.cs;
  assign bus.mem_we    = ctl_q.we;
  assign bus.mem_oe    = ctl_q.oe;
  assign busy          = busy_q;
  assign txn_count     = txn_q;

endmodule
